// File: rtl/elevator_car_drive.sv
// Car-side drive for the elevator controller.
// Accepts single-floor move commands and door-open requests, models travel
// and door dwell time with an 8-bit down-counter, and reports floor, motion,
// arrival, door-cycle-complete and illegal-command pulses.
// Door and motion are interlocked structurally: moving is only set on the
// IDLE->MOVE transition, door_open only on IDLE->DOOR, and both are cleared
// on the way back to IDLE, so the two can never be active together.

module elevator_car_drive #(
    parameter int TRAVEL_TICKS = 8,
    parameter int DOOR_TICKS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    input  logic       open_req,
    output logic [1:0] floor,
    output logic [1:0] moving,
    output logic       arrived,
    output logic       door_open,
    output logic       door_done,
    output logic       fault
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_MOVE  = 2'b01;
    localparam logic [1:0] ST_DOOR  = 2'b10;

    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DN   = 2'b01;
    localparam logic [1:0] DIR_NONE = 2'b00;

    localparam logic [1:0] FLOOR_BOT = 2'b00;
    localparam logic [1:0] FLOOR_TOP = 2'b11;

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_TICKS - 1);
    localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_TICKS - 1);

    // Out-of-range tick counts make the timer load meaningless; flag them.
    generate
        if ((TRAVEL_TICKS < 1) || (TRAVEL_TICKS > 255) ||
            (DOOR_TICKS < 1) || (DOOR_TICKS > 255)) begin : g_param_check
            $error("elevator_car_drive: TRAVEL_TICKS and DOOR_TICKS must be 1..255");
        end
    endgenerate

    logic [1:0] state_q,     state_d;
    logic [7:0] timer_q,     timer_d;
    logic [1:0] floor_q,     floor_d;
    logic [1:0] moving_q,    moving_d;
    logic       arrived_q,   arrived_d;
    logic       door_open_q, door_open_d;
    logic       door_done_q, door_done_d;
    logic       fault_q,     fault_d;

    // Ready only when idle with no pending door request, and never in reset.
    assign cmd_ready = rst & (state_q == ST_IDLE) & ~open_req;

    // Next-state logic: IDLE arbitration, travel timing and door dwell/hold.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        floor_d     = floor_q;
        moving_d    = moving_q;
        door_open_d = door_open_q;
        arrived_d   = 1'b0;
        door_done_d = 1'b0;
        fault_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (open_req) begin
                    // Door request outranks any command presented this cycle.
                    state_d     = ST_DOOR;
                    door_open_d = 1'b1;
                    timer_d     = DOOR_LOAD;
                end else if (cmd_valid) begin
                    case (cmd_dir)
                        DIR_UP: begin
                            if (floor_q != FLOOR_TOP) begin
                                state_d  = ST_MOVE;
                                moving_d = DIR_UP;
                                timer_d  = TRAVEL_LOAD;
                            end else begin
                                fault_d = 1'b1;
                            end
                        end
                        DIR_DN: begin
                            if (floor_q != FLOOR_BOT) begin
                                state_d  = ST_MOVE;
                                moving_d = DIR_DN;
                                timer_d  = TRAVEL_LOAD;
                            end else begin
                                fault_d = 1'b1;
                            end
                        end
                        DIR_NONE: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            fault_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (timer_q == 8'd0) begin
                    // The legality check at acceptance keeps this from wrapping.
                    if (moving_q == DIR_UP) begin
                        floor_d = floor_q + 2'd1;
                    end else begin
                        floor_d = floor_q - 2'd1;
                    end
                    moving_d  = DIR_NONE;
                    arrived_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            ST_DOOR: begin
                if (timer_q == 8'd0) begin
                    if (open_req) begin
                        // Door-hold: start another full dwell period.
                        timer_d = DOOR_LOAD;
                    end else begin
                        door_open_d = 1'b0;
                        door_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                timer_d     = 8'd0;
                moving_d    = DIR_NONE;
                door_open_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any move or door cycle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= 8'd0;
            floor_q     <= FLOOR_BOT;
            moving_q    <= DIR_NONE;
            arrived_q   <= 1'b0;
            door_open_q <= 1'b0;
            door_done_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            floor_q     <= floor_d;
            moving_q    <= moving_d;
            arrived_q   <= arrived_d;
            door_open_q <= door_open_d;
            door_done_q <= door_done_d;
            fault_q     <= fault_d;
        end
    end

    assign floor     = floor_q;
    assign moving    = moving_q;
    assign arrived   = arrived_q;
    assign door_open = door_open_q;
    assign door_done = door_done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_elevator_car_drive.sv
// Self-checking bench for elevator_car_drive.
// Each stimulus step pushes the expected outcome (pulse kind, floor, cycles
// to the pulse, door-open cycles, moving cycles) onto a scoreboard queue;
// the observed outcome is collected from the pins and compared on pop.

module tb_elevator_car_drive;

    localparam int T = 8;
    localparam int D = 5;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_ARR  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;
    localparam logic [1:0] K_FLT  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] fl;
        logic [7:0] cyc;
        logic [7:0] door_cyc;
        logic [7:0] mv_cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_dir = 2'b00;
    logic       open_req = 1'b0;
    logic       cmd_ready;
    logic [1:0] floor;
    logic [1:0] moving;
    logic       arrived;
    logic       door_open;
    logic       door_done;
    logic       fault;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t sb[$];

    elevator_car_drive #(.TRAVEL_TICKS(T), .DOOR_TICKS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .open_req  (open_req),
        .floor     (floor),
        .moving    (moving),
        .arrived   (arrived),
        .door_open (door_open),
        .door_done (door_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input logic [1:0] k, input logic [1:0] f,
                               input int c, input int dc, input int mc);
        ev_t e;
        e.kind     = k;
        e.fl       = f;
        e.cyc      = 8'(c);
        e.door_cyc = 8'(dc);
        e.mv_cyc   = 8'(mc);
        return e;
    endfunction

    // Expected outcome of a move from the floor it leaves.
    function automatic ev_t exp_move(input logic [1:0] dest);
        return mk(K_ARR, dest, T + 1, 0, T);
    endfunction

    // Door cycle with open_req seen on 'hold' edges, reloading every D edges.
    function automatic ev_t exp_door(input logic [1:0] f, input int hold);
        int off;
        off = D * ((hold - 1) / D + 1);
        return mk(K_DONE, f, off + 1, off, 0);
    endfunction

    task automatic report(input string name, input ev_t got, input ev_t need);
        n_fail++;
        $display("FAIL %s: got kind=%0d floor=%0d cyc=%0d door=%0d mv=%0d, need kind=%0d floor=%0d cyc=%0d door=%0d mv=%0d",
                 name, got.kind, got.fl, got.cyc, got.door_cyc, got.mv_cyc,
                 need.kind, need.fl, need.cyc, need.door_cyc, need.mv_cyc);
    endtask

    // Drive one step from a negedge and watch until the first pulse (bounded).
    task automatic drive(input logic valid, input logic [1:0] dir, input int hold,
                         output ev_t obs);
        int left;
        obs       = '0;
        left      = hold;
        cmd_valid = valid;
        cmd_dir   = dir;
        open_req  = (left > 0);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (left > 0) left--;
            open_req = (left > 0);
            n_checks++;
            if ((moving != 2'b00 && door_open) || ($countones({arrived, door_done, fault}) > 1)) begin
                n_fail++;
                $display("FAIL interlock: moving=%b door_open=%b pulses=%b%b%b",
                         moving, door_open, arrived, door_done, fault);
            end
            if (door_open)        obs.door_cyc = obs.door_cyc + 8'd1;
            if (moving != 2'b00)  obs.mv_cyc   = obs.mv_cyc + 8'd1;
            if (arrived || door_done || fault) begin
                obs.kind = arrived ? K_ARR : (door_done ? K_DONE : K_FLT);
                obs.fl   = floor;
                obs.cyc  = 8'(c);
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, floor, moving, arrived, door_open, door_done, fault} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b need %b",
                     {cmd_ready, floor, moving, arrived, door_open, door_done, fault}, 9'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b need 1", cmd_ready);
        end
    endtask

    task automatic test_illegal_at_bottom();
        ev_t obs, e;
        sb.push_back(mk(K_FLT, 2'b00, 1, 0, 0));
        drive(1'b1, 2'b01, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("down_at_bottom", obs, e);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_fault: got %b need 1", cmd_ready);
        end
        sb.push_back(mk(K_FLT, 2'b00, 1, 0, 0));
        drive(1'b1, 2'b11, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("illegal_11", obs, e);
    endtask

    task automatic test_move_up();
        ev_t obs, e;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before_move: got %b need 1", cmd_ready);
        end
        sb.push_back(exp_move(2'b01));
        drive(1'b1, 2'b10, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("move_up_0_1", obs, e);
        n_checks++;
        if (moving !== 2'b00) begin
            n_fail++;
            $display("FAIL moving_after_arrive: got %b need 00", moving);
        end
    endtask

    task automatic test_top_boundary();
        ev_t obs, e;
        sb.push_back(exp_move(2'b10));
        drive(1'b1, 2'b10, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("move_up_1_2", obs, e);
        sb.push_back(exp_move(2'b11));
        drive(1'b1, 2'b10, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("move_up_2_3", obs, e);
        sb.push_back(mk(K_FLT, 2'b11, 1, 0, 0));
        drive(1'b1, 2'b10, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("up_at_top", obs, e);
        sb.push_back(exp_move(2'b10));
        drive(1'b1, 2'b01, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("move_down_3_2", obs, e);
    endtask

    task automatic test_door_blocks_cmd();
        ev_t obs, e;
        open_req  = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 2'b10;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_with_open_req: got %b need 0", cmd_ready);
        end
        sb.push_back(exp_door(2'b10, 1));
        drive(1'b1, 2'b10, 1, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("door_single", obs, e);
    endtask

    task automatic test_door_hold();
        ev_t obs, e;
        sb.push_back(exp_door(2'b10, 12));
        drive(1'b0, 2'b00, 12, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("door_hold_12", obs, e);
    endtask

    task automatic test_back_to_back();
        ev_t obs, e;
        sb.push_back(exp_door(2'b10, 1));
        drive(1'b0, 2'b00, 1, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("door_b2b_1", obs, e);
        sb.push_back(exp_door(2'b10, 1));
        drive(1'b0, 2'b00, 1, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("door_b2b_2", obs, e);
        sb.push_back(exp_move(2'b01));
        drive(1'b1, 2'b01, 0, obs);
        e = sb.pop_front();
        n_checks++;
        if (obs !== e) report("move_after_door", obs, e);
    endtask

    task automatic test_reset_mid_move();
        int pulses;
        cmd_valid = 1'b1;
        cmd_dir   = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({floor, moving} !== 4'b0110) begin
            n_fail++;
            $display("FAIL mid_move_state: got %b need 0110", {floor, moving});
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, floor, moving, arrived, door_open, door_done, fault} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b need %b",
                     {cmd_ready, floor, moving, arrived, door_open, door_done, fault}, 9'b0);
        end
        @(negedge clk);
        rst    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arrived || door_done || fault || moving != 2'b00) pulses++;
        end
        n_checks++;
        if (pulses != 0 || floor !== 2'b00) begin
            n_fail++;
            $display("FAIL after_abort: got activity=%0d floor=%b need activity=0 floor=00",
                     pulses, floor);
        end
    endtask

    initial begin
        test_reset();
        test_illegal_at_bottom();
        test_move_up();
        test_top_boundary();
        test_door_blocks_cmd();
        test_door_hold();
        test_back_to_back();
        test_reset_mid_move();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
